// File: rtl/reg_writeback_unit.sv
// Register-file write-port driver: merges single-cycle EX results with
// in-order long-latency completions and tracks pending LC destinations.
module reg_writeback_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int TAG_DEPTH = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_rdst,
  input  logic              ex_jal,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              lc_issue,
  input  logic [ADDR_W-1:0] lc_dest,
  output logic              lc_issue_ok,
  input  logic              lc_valid,
  input  logic [DATA_W-1:0] lc_data,
  output logic              lc_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_dest,
  output logic              stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              err
);

  localparam int TPW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int BPW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int MAXD = (TAG_DEPTH > BUF_DEPTH) ? TAG_DEPTH : BUF_DEPTH;
  localparam int CW   = $clog2(MAXD + 1);

  logic [ADDR_W-1:0] tag_mem [TAG_DEPTH];
  logic [TAG_DEPTH-1:0] tag_vld;
  logic [TPW-1:0]    tag_wp, tag_rp;
  logic [CW-1:0]     tag_cnt;

  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
  logic [BPW-1:0]    buf_wp, buf_rp;
  logic [CW-1:0]     buf_cnt;

  logic [ADDR_W-1:0] ex_dest;
  logic [ADDR_W-1:0] head_tag;
  logic              ex_wr, lc_pop, unmatched;
  logic              tag_push, buf_push, issue_err, comp_err;

  function automatic logic reg_hit(input logic [ADDR_W-1:0] r,
                                   input logic [ADDR_W-1:0] t);
    return (r != '0) && (r == t);
  endfunction

  // Occupancy-based flow control from registered counts only.
  assign lc_issue_ok = tag_cnt < CW'(TAG_DEPTH);
  assign lc_ready    = buf_cnt < CW'(BUF_DEPTH);

  // Destination resolution, write-port arbitration and FIFO handshakes.
  always_comb begin
    ex_dest   = ex_jal ? ADDR_W'(31) : (ex_rdst ? ex_rd : ex_rt);
    ex_wr     = ex_valid && (ex_dest != '0);
    lc_pop    = !ex_wr && (buf_cnt != '0);
    unmatched = tag_cnt > buf_cnt;
    tag_push  = lc_issue && lc_issue_ok;
    issue_err = lc_issue && !lc_issue_ok;
    buf_push  = lc_valid && lc_ready && unmatched;
    comp_err  = lc_valid && !unmatched;
    head_tag  = tag_mem[tag_rp];
  end

  // Decode hazard: any pending tag, plus the write currently in flight to the regfile.
  always_comb begin
    stall = wr_en && (reg_hit(id_rs, wr_addr) || reg_hit(id_rt, wr_addr) ||
                      reg_hit(id_dest, wr_addr));
    for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
      if (tag_vld[TPW'(i)] &&
          (reg_hit(id_rs, tag_mem[TPW'(i)]) || reg_hit(id_rt, tag_mem[TPW'(i)]) ||
           reg_hit(id_dest, tag_mem[TPW'(i)])))
        stall = 1'b1;
    end
  end

  // Destination tag FIFO; a per-slot valid bit makes the pending set directly searchable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_mem <= '{default: '0};
      tag_vld <= '0;
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_push) begin
        tag_mem[tag_wp] <= lc_dest;
        tag_vld[tag_wp] <= 1'b1;
        tag_wp <= (tag_wp == TPW'(TAG_DEPTH - 1)) ? '0 : tag_wp + TPW'(1);
      end
      if (lc_pop) begin
        tag_vld[tag_rp] <= 1'b0;
        tag_rp <= (tag_rp == TPW'(TAG_DEPTH - 1)) ? '0 : tag_rp + TPW'(1);
      end
      tag_cnt <= tag_cnt + CW'(tag_push) - CW'(lc_pop);
    end
  end

  // Completed-result buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_mem <= '{default: '0};
      buf_wp  <= '0;
      buf_rp  <= '0;
      buf_cnt <= '0;
    end else begin
      if (buf_push) begin
        buf_mem[buf_wp] <= lc_data;
        buf_wp <= (buf_wp == BPW'(BUF_DEPTH - 1)) ? '0 : buf_wp + BPW'(1);
      end
      if (lc_pop)
        buf_rp <= (buf_rp == BPW'(BUF_DEPTH - 1)) ? '0 : buf_rp + BPW'(1);
      buf_cnt <= buf_cnt + CW'(buf_push) - CW'(lc_pop);
    end
  end

  // Registered write port and sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (ex_wr) begin
        wr_en   <= 1'b1;
        wr_addr <= ex_dest;
        wr_data <= ex_data;
      end else if (lc_pop && (head_tag != '0)) begin
        wr_en   <= 1'b1;
        wr_addr <= head_tag;
        wr_data <= buf_mem[buf_rp];
      end
      if (issue_err || comp_err)
        err <= 1'b1;
    end
  end

endmodule
